// File: rtl/tmds_ctrl_pkg.sv
// ============================================================================
//  Module   : tmds_ctrl_pkg
//  Purpose  : Shared types and phase constants for the TMDS lane sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tmds_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CTRL  = 2'd1,
        GUARD = 2'd2,
        VIDEO = 2'd3
    } state_t;

    localparam logic [1:0] BSEL_VIDEO = 2'b00;
    localparam logic [1:0] BSEL_CTRL  = 2'b01;
    localparam logic [1:0] BSEL_GUARD = 2'b10;

    localparam int unsigned WORD_BITS = 10;

    localparam logic [3:0] PH_D1 = 4'd0;
    localparam logic [3:0] PH_D2 = 4'd2;
    localparam logic [3:0] PH_S1 = 4'd4;
    localparam logic [3:0] PH_S2 = 4'd6;
    localparam logic [3:0] PH_SR = 4'd9;

endpackage

`default_nettype wire

// File: rtl/tmds_encoder_ctrl_if.sv
// ============================================================================
//  Module   : tmds_encoder_ctrl_if
//  Purpose  : Control/strobe bundle between the lane sequencer and its datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface tmds_encoder_ctrl_if;
    logic       enable;
    logic       video_de;
    logic [1:0] blank_sel;
    logic       D1_load;
    logic       D2_load;
    logic       S1_load;
    logic       S2_load;
    logic       SR0_load;
    logic       SR1_load;
    logic       out_sel;
    logic       word_req;
    logic       tmds_valid;
    logic [3:0] bit_cnt;

    modport master (
        output enable, video_de,
        input  blank_sel, D1_load, D2_load, S1_load, S2_load,
               SR0_load, SR1_load, out_sel, word_req, tmds_valid, bit_cnt
    );

    modport slave (
        input  enable, video_de,
        output blank_sel, D1_load, D2_load, S1_load, S2_load,
               SR0_load, SR1_load, out_sel, word_req, tmds_valid, bit_cnt
    );
endinterface

`default_nettype wire

// File: rtl/tmds_word_phase.sv
// ============================================================================
//  Module   : tmds_word_phase
//  Purpose  : Mod-10 word phase counter with hold and synchronous clear.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_word_phase
    import tmds_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hold,
    output logic [3:0] o_bit_cnt,
    output logic [3:0] o_cnt_nxt,
    output logic       o_wrap
);
    logic [3:0] r_cnt;

    assign o_wrap    = !i_hold && (r_cnt == 4'(WORD_BITS - 1));
    assign o_cnt_nxt = (i_hold || o_wrap) ? 4'd0 : r_cnt + 4'd1;
    assign o_bit_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= o_cnt_nxt;
        end
    end
endmodule

`default_nettype wire

// File: rtl/tmds_encoder_ctrl.sv
// ============================================================================
//  Module   : tmds_encoder_ctrl
//  Purpose  : TMDS lane sequencer: load strobes, SR ping-pong, blank source.
//             Guard-band insertion enabled by defining TMDS_GUARD_BAND_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_encoder_ctrl
    import tmds_ctrl_pkg::*;
`ifdef TMDS_GUARD_BAND_EN
#(
    parameter int unsigned GUARD_WORDS = 2
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    tmds_encoder_ctrl_if.slave   bus
);
    state_t     r_state;
    logic [1:0] r_bsel;
    logic       r_par;
    logic       r_out_sel;
    logic       r_valid;
    logic       r_stop;
    logic       r_d1, r_d2, r_s1, r_s2, r_sr0, r_sr1;
`ifdef TMDS_GUARD_BAND_EN
    logic [3:0] r_guard_cnt;
`endif

    logic [3:0] w_bit_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_wrap;
    logic       w_idle;
    logic       w_act_nxt;
    logic       w_sr_ok;

    tmds_word_phase u_phase (
        .clk       (clk),
        .rst       (rst),
        .i_hold    (w_idle),
        .o_bit_cnt (w_bit_cnt),
        .o_cnt_nxt (w_cnt_nxt),
        .o_wrap    (w_wrap)
    );

    assign w_idle    = (r_state == IDLE);
    assign w_act_nxt = w_idle ? bus.enable : !(w_wrap && r_stop);
    // Shutdown is decided on entry to the last phase so the SR strobe can be withheld.
    assign w_sr_ok   = (w_cnt_nxt == PH_SR) && bus.enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bsel    <= BSEL_CTRL;
            r_par     <= 1'b0;
            r_out_sel <= 1'b0;
            r_valid   <= 1'b0;
            r_stop    <= 1'b0;
            r_d1      <= 1'b0;
            r_d2      <= 1'b0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_sr0     <= 1'b0;
            r_sr1     <= 1'b0;
`ifdef TMDS_GUARD_BAND_EN
            r_guard_cnt <= 4'd0;
`endif
        end else begin
            r_d1  <= w_act_nxt && (w_cnt_nxt == PH_D1);
            r_d2  <= w_act_nxt && (w_cnt_nxt == PH_D2);
            r_s1  <= w_act_nxt && (w_cnt_nxt == PH_S1);
            r_s2  <= w_act_nxt && (w_cnt_nxt == PH_S2);
            r_sr0 <= w_sr_ok && !r_par;
            r_sr1 <= w_sr_ok && r_par;
            if (w_cnt_nxt == PH_SR) begin
                r_stop <= !bus.enable;
            end

            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_state <= CTRL;
                        r_bsel  <= BSEL_CTRL;
                    end
                end
                default: begin
                    if (w_wrap) begin
                        if (r_stop) begin
                            r_state <= IDLE;
                            r_bsel  <= BSEL_CTRL;
                            r_valid <= 1'b0;
                        end else begin
                            r_par     <= !r_par;
                            r_out_sel <= r_par;
                            r_valid   <= 1'b1;
                            case (r_state)
                                CTRL: begin
                                    if (bus.video_de) begin
`ifdef TMDS_GUARD_BAND_EN
                                        r_state     <= GUARD;
                                        r_bsel      <= BSEL_GUARD;
                                        r_guard_cnt <= 4'(GUARD_WORDS - 1);
`else
                                        r_state <= VIDEO;
                                        r_bsel  <= BSEL_VIDEO;
`endif
                                    end
                                end
`ifdef TMDS_GUARD_BAND_EN
                                GUARD: begin
                                    if (!bus.video_de) begin
                                        r_state <= CTRL;
                                        r_bsel  <= BSEL_CTRL;
                                    end else if (r_guard_cnt == 4'd0) begin
                                        r_state <= VIDEO;
                                        r_bsel  <= BSEL_VIDEO;
                                    end else begin
                                        r_guard_cnt <= r_guard_cnt - 4'd1;
                                    end
                                end
`endif
                                VIDEO: begin
                                    if (!bus.video_de) begin
                                        r_state <= CTRL;
                                        r_bsel  <= BSEL_CTRL;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.blank_sel  = r_bsel;
    assign bus.D1_load    = r_d1;
    assign bus.D2_load    = r_d2;
    assign bus.S1_load    = r_s1;
    assign bus.S2_load    = r_s2;
    assign bus.SR0_load   = r_sr0;
    assign bus.SR1_load   = r_sr1;
    assign bus.out_sel    = r_out_sel;
    assign bus.word_req   = r_d1;
    assign bus.tmds_valid = r_valid;
    assign bus.bit_cnt    = w_bit_cnt;
endmodule

`default_nettype wire

// File: tb/tb_tmds_encoder_ctrl.sv
// ============================================================================
//  Module   : tb_tmds_encoder_ctrl
//  Purpose  : Self-checking bench for the TMDS lane sequencer (both builds).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tmds_encoder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    tmds_encoder_ctrl_if bus ();

    tmds_encoder_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef TMDS_GUARD_BAND_EN
    localparam bit HAS_GUARD = 1'b1;
    localparam int RST_K     = 153;
`else
    localparam bit HAS_GUARD = 1'b0;
    localparam int RST_K     = 133;
`endif
    localparam int G_WORDS = 2;

    // Reference model: word-level view of the lane (phase, blank source, SR parity).
    bit m_started = 0;
    bit m_active  = 0;
    int m_phase   = 0;
    int m_blank   = 1;
    int m_gleft   = 0;
    bit m_par     = 0;
    bit m_outsel  = 0;
    bit m_valid   = 0;
    bit m_stop    = 0;

    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            m_active = 0; m_phase = 0; m_blank = 1; m_gleft = 0;
            m_par = 0; m_outsel = 0; m_valid = 0; m_stop = 0;
        end else if (!m_active) begin
            if (bus.enable) begin
                m_active = 1; m_phase = 0; m_blank = 1;
            end
        end else if (m_phase == 9) begin
            m_phase = 0;
            if (m_stop) begin
                m_active = 0; m_valid = 0; m_blank = 1;
            end else begin
                m_outsel = m_par;
                m_par    = !m_par;
                m_valid  = 1;
                if (m_blank == 1) begin
                    if (bus.video_de) begin
                        if (HAS_GUARD) begin m_blank = 2; m_gleft = G_WORDS; end
                        else m_blank = 0;
                    end
                end else if (m_blank == 2) begin
                    if (!bus.video_de) m_blank = 1;
                    else begin
                        m_gleft = m_gleft - 1;
                        if (m_gleft == 0) m_blank = 0;
                    end
                end else if (!bus.video_de) begin
                    m_blank = 1;
                end
            end
        end else begin
            if (m_phase == 8) m_stop = !bus.enable;
            m_phase = m_phase + 1;
        end
    end

    function automatic logic [14:0] exp_vec();
        bit sr;
        sr = m_active && (m_phase == 9) && !m_stop;
        return {2'(m_blank),
                m_active && m_phase == 0, m_active && m_phase == 2,
                m_active && m_phase == 4, m_active && m_phase == 6,
                sr && !m_par, sr && m_par, m_outsel,
                m_active && m_phase == 0, m_valid, 4'(m_phase)};
    endfunction

    wire logic [14:0] w_dut_vec = {bus.blank_sel, bus.D1_load, bus.D2_load, bus.S1_load,
                                   bus.S2_load, bus.SR0_load, bus.SR1_load, bus.out_sel,
                                   bus.word_req, bus.tmds_valid, bus.bit_cnt};

    always @(negedge clk) begin
        if (m_started) begin
            n_cmp++;
            if (w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t got %h required %h", $time, w_dut_vec, exp_vec());
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.video_de = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bit_cnt", int'(bus.bit_cnt), 0);
        chk("rst_blank",   int'(bus.blank_sel), 1);
        chk("rst_outsel",  int'(bus.out_sel), 0);
        chk("rst_valid",   int'(bus.tmds_valid), 0);
        chk("rst_d1",      int'(bus.D1_load), 0);
        rst        = 1'b0;
        bus.enable = 1'b1;

        for (int k = 0; k <= RST_K + 30; k++) begin
            @(negedge clk);
            case (k)
                0:   begin chk("t1_d1", int'(bus.D1_load), 1); chk("t1_valid0", int'(bus.tmds_valid), 0); end
                2:   chk("t1_d2", int'(bus.D2_load), 1);
                4:   chk("t1_s1", int'(bus.S1_load), 1);
                6:   chk("t1_s2", int'(bus.S2_load), 1);
                9:   chk("t1_sr0", int'(bus.SR0_load), 1);
                10:  begin chk("t1_outsel0", int'(bus.out_sel), 0); chk("t1_valid1", int'(bus.tmds_valid), 1); end
                15:  chk("t1_blank", int'(bus.blank_sel), 1);
                19:  chk("t1_sr1", int'(bus.SR1_load), 1);
                20:  chk("t1_outsel1", int'(bus.out_sel), 1);
                35:  chk("t2_guard_w1", int'(bus.blank_sel), HAS_GUARD ? 2 : 0);
                45:  chk("t2_guard_w2", int'(bus.blank_sel), HAS_GUARD ? 2 : 0);
                55:  begin chk("t2_video", int'(bus.blank_sel), 0); chk("t2_valid", int'(bus.tmds_valid), 1); end
                62:  chk("t3_ctrl", int'(bus.blank_sel), 1);
                75:  chk("t3_guard_drop", int'(bus.blank_sel), HAS_GUARD ? 2 : 0);
                85:  chk("t3_back_ctrl", int'(bus.blank_sel), 1);
                109: begin chk("t4_sr0_supp", int'(bus.SR0_load), 0); chk("t4_sr1_supp", int'(bus.SR1_load), 0); end
                112: begin
                    chk("t4_outsel_held", int'(bus.out_sel), 1);
                    chk("t4_valid", int'(bus.tmds_valid), 0);
                    chk("t4_bit_cnt", int'(bus.bit_cnt), 0);
                    chk("t4_d1", int'(bus.D1_load), 0);
                end
                116: begin chk("t4_restart_d1", int'(bus.D1_load), 1); chk("t4_restart_cnt", int'(bus.bit_cnt), 0); end
                RST_K: begin chk("t5_pre_blank", int'(bus.blank_sel), 0); chk("t5_pre_cnt", int'(bus.bit_cnt), 7); end
                RST_K + 1: begin
                    chk("t5_cnt", int'(bus.bit_cnt), 0);
                    chk("t5_blank", int'(bus.blank_sel), 1);
                    chk("t5_outsel", int'(bus.out_sel), 0);
                    chk("t5_valid", int'(bus.tmds_valid), 0);
                    chk("t5_strobes", int'({bus.D1_load, bus.D2_load, bus.S1_load, bus.S2_load,
                                           bus.SR0_load, bus.SR1_load}), 0);
                end
                default: ;
            endcase
            case (k)
                24:        bus.video_de = 1'b1;
                57:        bus.video_de = 1'b0;
                64:        bus.video_de = 1'b1;
                74:        bus.video_de = 1'b0;
                105:       bus.enable   = 1'b0;
                115:       bus.enable   = 1'b1;
                120:       bus.video_de = 1'b1;
                RST_K:     rst = 1'b1;
                RST_K + 1: rst = 1'b0;
                default: ;
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
